target_frame_sequencer: RTL and testbench
=========================================

Name: target_frame_sequencer

Overview:
- Frame-level controller behind the marker-detection pipeline (rgb_compress -> get_target).
- On each vsync rising edge it snapshots the NUM_TARGETS results and applies a per-target hold ("coast") policy so briefly lost markers persist.
- It then streams the targets one at a time to a downstream consumer (overlay/UART) over a valid/ready handshake.
- Owns frame counting and overrun detection; the detector itself stays free-running.

Parameters:
- NUM_TARGETS, 4, number of target slots (index width $clog2(NUM_TARGETS), min 1 bit)
- SCREEN_WIDTH, 1280, sets XW = $clog2(SCREEN_WIDTH)
- SCREEN_HEIGHT, 720, sets YW = $clog2(SCREEN_HEIGHT)+1 (y and diameter width)
- HOLD_FRAMES, 3, consecutive missed frames a target is coasted before being dropped; 0 = drop immediately
- FRAME_CNT_W, 16, width of frame counter

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- rst_n_in  in  1  reset, asynchronous assert, active-low
- vsync_in  in  1  frame sync level from video timing
- xcount_in  in  NUM_TARGETS*XW  packed x centres, target i at bits [i*XW +: XW]
- ycount_in  in  NUM_TARGETS*YW  packed y centres, same packing
- diameter_in  in  NUM_TARGETS*YW  packed diameters, same packing
- valid_in  in  NUM_TARGETS  bit i = target i detected this frame (LSB = target 0, no reversal)
- out_ready_in  in  1  consumer ready
- out_valid_out  out  1  record available
- out_index_out  out  $clog2(NUM_TARGETS)  target slot of current record
- out_x_out  out  XW  held x
- out_y_out  out  YW  held y
- out_diameter_out  out  YW  held diameter
- out_present_out  out  1  1 = fresh or coasting, 0 = lost (coords meaningless, driven 0)
- out_fresh_out  out  1  1 = detected in this frame (not coasted)
- frame_done_out  out  1  one-cycle pulse after last record accepted
- frame_count_out  out  FRAME_CNT_W  snapshots taken, wraps modulo 2^FRAME_CNT_W
- overrun_out  out  1  sticky: a frame was dropped because streaming had not finished

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; all outputs 0; vsync_q 0; every slot present=0, miss_cnt=HOLD_FRAMES, coords 0; overrun 0; frame_count 0.
- Edge detect: vs_edge = vsync_in & ~vsync_q, vsync_q registered each cycle. An edge is seen in the cycle vsync_in first samples high.
- States: IDLE, SEND.
- IDLE + vs_edge: take snapshot (below), frame_count+1, index=0, go SEND. out_valid_out=1 from the next cycle.
  - Latency: edge cycle N -> record 0 visible in cycle N+1.
- Snapshot per slot i:
  - valid_in[i]=1: load x/y/diameter, miss_cnt=0, present=1, fresh=1.
  - else if present and miss_cnt<HOLD_FRAMES: miss_cnt+1, coords kept, present=1, fresh=0.
  - else: present=0, fresh=0, coords cleared to 0, miss_cnt saturates at HOLD_FRAMES.
- SEND:
  - out_* reflect slot[index] and remain stable while out_valid_out=1 and out_ready_in=0.
  - On out_valid_out & out_ready_in: index+1.
  - On handshake with index=NUM_TARGETS-1: frame_done_out pulses next cycle, out_valid_out drops, go IDLE.
- vs_edge in SEND, not on the final handshake cycle: overrun_out set (sticky until reset); the new frame is dropped, with no snapshot and no frame_count change; streaming continues.
- vs_edge coincident with final handshake: no overrun. frame_done pulses; snapshot is taken; frame_count+1; index=0; stay SEND. out_valid_out stays 1 continuously.
- vs_edge in IDLE on the cycle after frame_done: normal accept.
- out_ready_in is ignored in IDLE. out_valid_out never depends combinationally on out_ready_in.
- All registers clocked, no combinational input->output paths.

Decomposition:
- Shared package marker_pkg: XW/YW width functions, state enum {IDLE, SEND}, packed struct target_rec_t {x, y, diameter, present, fresh}.
- Sub-module target_hold_slot (one per target via generate): holds record and miss_cnt, implements the snapshot/coast rule on a load strobe.
- Top holds the FSM, index, edge detector, counters.

Test Plan:
- Reset mid-SEND (rst_n_in low while out_index_out=2) -> all outputs 0 immediately, async; after release next vs_edge streams index 0 with frame_count=1.
- valid_in=4'b0101, x0=100, x2=640, out_ready_in=1 -> indices 0..3 on 4 consecutive cycles starting N+1; present/fresh = 1,0,1,0; frame_done at N+5.
- HOLD_FRAMES=3, target 1 detected frame 1 at x=200 then absent frames 2-5 -> present=1, x=200, fresh=0 frames 2-4; present=0, x=0 frame 5.
- out_ready_in low 10 cycles on index 1 -> out_x_out/out_index_out stable throughout; advance one cycle after ready rises.
- vs_edge while stalled at index 1 -> overrun_out=1 sticky, frame_count unchanged, records unchanged; vs_edge on exactly the index-3 handshake -> no overrun, out_valid_out stays high, index 0 of new frame next cycle.
- 65536+1 frames -> frame_count_out wraps to 1.

Source files
------------

// File: rtl/marker_pkg.sv
// Shared types and width helpers for the marker target pipeline back end.
package marker_pkg;

    // Container width for stored coordinates; narrower fields are zero-extended into it.
    localparam int REC_W = 16;

    function automatic int calc_xw(input int screen_width);
        return $clog2(screen_width);
    endfunction

    function automatic int calc_yw(input int screen_height);
        return $clog2(screen_height) + 1;
    endfunction

    function automatic int calc_iw(input int num_targets);
        return (num_targets > 1) ? $clog2(num_targets) : 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [REC_W-1:0] x;
        logic [REC_W-1:0] y;
        logic [REC_W-1:0] diameter;
        logic             present;
        logic             fresh;
    } target_rec_t;

endpackage

// File: rtl/target_frame_sequencer_if.sv
// Per-record streaming handshake between the frame sequencer and its consumer.
interface target_frame_sequencer_if #(
    parameter int XW = 11,
    parameter int YW = 11,
    parameter int IW = 2
);
    logic          valid;
    logic          ready;
    logic [IW-1:0] index;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] diameter;
    logic          present;
    logic          fresh;
    logic          frame_done;

    modport master (
        output valid, index, x, y, diameter, present, fresh, frame_done,
        input  ready
    );

    modport slave (
        input  valid, index, x, y, diameter, present, fresh, frame_done,
        output ready
    );
endinterface

// File: rtl/target_hold_slot.sv
// One target slot: keeps the last record and coasts it for up to HOLD_FRAMES missed frames.
module target_hold_slot
    import marker_pkg::*;
#(
    parameter int XW          = 11,
    parameter int YW          = 11,
    parameter int HOLD_FRAMES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_detect,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic [YW-1:0] i_diameter,
    output target_rec_t   o_rec
);

    localparam int              MW       = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [MW-1:0]   HOLD_MAX = MW'(HOLD_FRAMES);

    target_rec_t   r_rec;
    logic [MW-1:0] r_miss;

    // NOTE: state is updated with <= so every slot samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec  <= '0;
            r_miss <= HOLD_MAX;
        end else if (i_load) begin
            if (i_detect) begin
                r_rec.x        <= REC_W'(i_x);
                r_rec.y        <= REC_W'(i_y);
                r_rec.diameter <= REC_W'(i_diameter);
                r_rec.present  <= 1'b1;
                r_rec.fresh    <= 1'b1;
                r_miss         <= '0;
            end else if (r_rec.present && (r_miss < HOLD_MAX)) begin
                r_rec.fresh <= 1'b0;
                r_miss      <= r_miss + MW'(1);
            end else begin
                r_rec  <= '0;
                r_miss <= HOLD_MAX;
            end
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/target_frame_sequencer.sv
// Snapshots detector results on vsync, applies hold policy, and streams one record per target.
module target_frame_sequencer
    import marker_pkg::*;
#(
    parameter int NUM_TARGETS   = 4,
    parameter int SCREEN_WIDTH  = 1280,
    parameter int SCREEN_HEIGHT = 720,
    parameter int HOLD_FRAMES   = 3,
    parameter int FRAME_CNT_W   = 16,
    localparam int XW = calc_xw(SCREEN_WIDTH),
    localparam int YW = calc_yw(SCREEN_HEIGHT),
    localparam int IW = calc_iw(NUM_TARGETS)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      vsync_in,
    input  logic [NUM_TARGETS*XW-1:0] xcount_in,
    input  logic [NUM_TARGETS*YW-1:0] ycount_in,
    input  logic [NUM_TARGETS*YW-1:0] diameter_in,
    input  logic [NUM_TARGETS-1:0]    valid_in,
    input  logic                      out_ready_in,
    output logic                      out_valid_out,
    output logic [IW-1:0]             out_index_out,
    output logic [XW-1:0]             out_x_out,
    output logic [YW-1:0]             out_y_out,
    output logic [YW-1:0]             out_diameter_out,
    output logic                      out_present_out,
    output logic                      out_fresh_out,
    output logic                      frame_done_out,
    output logic [FRAME_CNT_W-1:0]    frame_count_out,
    output logic                      overrun_out
);

    state_t                 r_state, w_state_next;
    logic                   r_vsync_q;
    logic [IW-1:0]          r_index, w_index_next;
    logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
    logic                   r_overrun, w_overrun_next;
    logic                   r_done;

    logic        w_edge, w_valid, w_hs, w_last, w_load;
    target_rec_t w_recs [NUM_TARGETS];
    target_rec_t w_cur;
    logic        w_unused_bits;

    target_frame_sequencer_if #(.XW(XW), .YW(YW), .IW(IW)) u_out_if ();

    assign w_edge  = vsync_in & ~r_vsync_q;
    assign w_valid = (r_state == SEND);
    assign w_hs    = w_valid & u_out_if.ready;
    assign w_last  = w_hs && (r_index == IW'(NUM_TARGETS - 1));

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_slot
        target_hold_slot #(
            .XW          (XW),
            .YW          (YW),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_slot (
            .clk        (clk_in),
            .rst_n      (rst_n_in),
            .i_load     (w_load),
            .i_detect   (valid_in[g]),
            .i_x        (xcount_in[g*XW +: XW]),
            .i_y        (ycount_in[g*YW +: YW]),
            .i_diameter (diameter_in[g*YW +: YW]),
            .o_rec      (w_recs[g])
        );
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_index_next     = r_index;
        w_frame_cnt_next = r_frame_cnt;
        w_overrun_next   = r_overrun;
        w_load           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_load           = 1'b1;
                    w_frame_cnt_next = r_frame_cnt + FRAME_CNT_W'(1);
                    w_index_next     = '0;
                    w_state_next     = SEND;
                end
            end
            SEND: begin
                if (w_hs) w_index_next = r_index + IW'(1);
                if (w_last) begin
                    w_index_next = '0;
                    if (w_edge) begin
                        w_load           = 1'b1;
                        w_frame_cnt_next = r_frame_cnt + FRAME_CNT_W'(1);
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (w_edge) begin
                    // Streaming still busy: the new frame is dropped and flagged.
                    w_overrun_next = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: asynchronous active-low reset clears every state register, including the flags.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_vsync_q   <= 1'b0;
            r_index     <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_vsync_q   <= vsync_in;
            r_index     <= w_index_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_overrun   <= w_overrun_next;
            r_done      <= w_last;
        end
    end

    assign w_cur         = w_recs[r_index];
    assign w_unused_bits = ^w_cur;

    // Record fields are forced to zero whenever no record is being offered.
    assign u_out_if.valid      = w_valid;
    assign u_out_if.index      = r_index;
    assign u_out_if.x          = w_valid ? w_cur.x[XW-1:0]        : '0;
    assign u_out_if.y          = w_valid ? w_cur.y[YW-1:0]        : '0;
    assign u_out_if.diameter   = w_valid ? w_cur.diameter[YW-1:0] : '0;
    assign u_out_if.present    = w_valid & w_cur.present;
    assign u_out_if.fresh      = w_valid & w_cur.fresh;
    assign u_out_if.frame_done = r_done;
    assign u_out_if.ready      = out_ready_in;

    assign out_valid_out    = u_out_if.valid;
    assign out_index_out    = u_out_if.index;
    assign out_x_out        = u_out_if.x;
    assign out_y_out        = u_out_if.y;
    assign out_diameter_out = u_out_if.diameter;
    assign out_present_out  = u_out_if.present;
    assign out_fresh_out    = u_out_if.fresh;
    assign frame_done_out   = u_out_if.frame_done;
    assign frame_count_out  = r_frame_cnt;
    assign overrun_out      = r_overrun;

endmodule

// File: tb/tb_target_frame_sequencer.sv
// Directed bench for target_frame_sequencer with a reference slot model feeding a record scoreboard.
module tb_target_frame_sequencer;
    import marker_pkg::*;

    localparam int NT   = 4;
    localparam int HOLD = 3;
    localparam int FCW  = 8;
    localparam int XW   = calc_xw(1280);
    localparam int YW   = calc_yw(720);
    localparam int IW   = calc_iw(NT);

    typedef struct {
        int idx;
        int x;
        int y;
        int d;
        bit present;
        bit fresh;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vsync = 1'b0;
    logic [NT*XW-1:0]  xcount = '0;
    logic [NT*YW-1:0]  ycount = '0;
    logic [NT*YW-1:0]  diam = '0;
    logic [NT-1:0]     det = '0;
    logic [FCW-1:0]    frame_count;
    logic              overrun;

    target_frame_sequencer_if #(.XW(XW), .YW(YW), .IW(IW)) u_if ();

    target_frame_sequencer #(
        .NUM_TARGETS   (NT),
        .SCREEN_WIDTH  (1280),
        .SCREEN_HEIGHT (720),
        .HOLD_FRAMES   (HOLD),
        .FRAME_CNT_W   (FCW)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .vsync_in         (vsync),
        .xcount_in        (xcount),
        .ycount_in        (ycount),
        .diameter_in      (diam),
        .valid_in         (det),
        .out_ready_in     (u_if.ready),
        .out_valid_out    (u_if.valid),
        .out_index_out    (u_if.index),
        .out_x_out        (u_if.x),
        .out_y_out        (u_if.y),
        .out_diameter_out (u_if.diameter),
        .out_present_out  (u_if.present),
        .out_fresh_out    (u_if.fresh),
        .frame_done_out   (u_if.frame_done),
        .frame_count_out  (frame_count),
        .overrun_out      (overrun)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   m_x[NT], m_y[NT], m_d[NT], m_miss[NT];
    bit   m_present[NT];
    int   in_x[NT], in_y[NT], in_d[NT];
    int   total = 0;
    int   bad = 0;
    int   exp_frames = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_present[i] = 1'b0;
            m_miss[i]    = HOLD;
            m_x[i] = 0; m_y[i] = 0; m_d[i] = 0;
        end
        q.delete();
        exp_frames = 0;
    endtask

    task automatic drive_inputs(input logic [NT-1:0] mask);
        det = mask;
        for (int i = 0; i < NT; i++) begin
            xcount[i*XW +: XW] = in_x[i][XW-1:0];
            ycount[i*YW +: YW] = in_y[i][YW-1:0];
            diam[i*YW +: YW]   = in_d[i][YW-1:0];
        end
    endtask

    // Reference hold policy; pushes the four records the next frame must produce.
    task automatic snapshot(input logic [NT-1:0] mask);
        exp_t e;
        for (int i = 0; i < NT; i++) begin
            e.idx = i;
            if (mask[i]) begin
                m_x[i] = in_x[i]; m_y[i] = in_y[i]; m_d[i] = in_d[i];
                m_miss[i] = 0; m_present[i] = 1'b1; e.fresh = 1'b1;
            end else if (m_present[i] && m_miss[i] < HOLD) begin
                m_miss[i]++; e.fresh = 1'b0;
            end else begin
                m_present[i] = 1'b0; m_miss[i] = HOLD; e.fresh = 1'b0;
                m_x[i] = 0; m_y[i] = 0; m_d[i] = 0;
            end
            e.present = m_present[i];
            e.x = m_x[i]; e.y = m_y[i]; e.d = m_d[i];
            q.push_back(e);
        end
        exp_frames++;
    endtask

    task automatic send_vsync(input logic [NT-1:0] mask);
        @(negedge clk);
        drive_inputs(mask);
        vsync = 1'b1;
        snapshot(mask);
        @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic check_rec(input int k, output exp_t e);
        if (q.size() == 0) begin
            check($sformatf("rec%0d_queue", k), 32'(0), 32'(1));
            e = '{default: 0};
            return;
        end
        e = q.pop_front();
        check($sformatf("rec%0d_valid", k),   32'(u_if.valid),    32'(1));
        check($sformatf("rec%0d_index", k),   32'(u_if.index),    32'(e.idx));
        check($sformatf("rec%0d_x", k),       32'(u_if.x),        32'(e.x));
        check($sformatf("rec%0d_y", k),       32'(u_if.y),        32'(e.y));
        check($sformatf("rec%0d_diam", k),    32'(u_if.diameter), 32'(e.d));
        check($sformatf("rec%0d_present", k), 32'(u_if.present),  32'(e.present));
        check($sformatf("rec%0d_fresh", k),   32'(u_if.fresh),    32'(e.fresh));
    endtask

    task automatic check_done();
        logic [FCW-1:0] cnt;
        cnt = exp_frames[FCW-1:0];
        check("done_pulse", 32'(u_if.frame_done), 32'(1));
        check("done_valid", 32'(u_if.valid),      32'(0));
        check("done_count", 32'(frame_count),     32'(cnt));
    endtask

    // Called at the falling edge where record 0 is first visible, with ready held high.
    task automatic stream_all();
        exp_t e;
        for (int k = 0; k < NT; k++) begin
            check_rec(k, e);
            @(negedge clk);
        end
        check_done();
    endtask

    task automatic set_target(input int i, input int x, input int y, input int d);
        in_x[i] = x; in_y[i] = y; in_d[i] = d;
    endtask

    initial begin
        exp_t e;
        exp_t stall_e;
        u_if.ready = 1'b0;
        for (int i = 0; i < NT; i++) set_target(i, 0, 0, 0);
        model_reset();

        // Reset state, and ready is ignored while idle.
        repeat (3) @(negedge clk);
        check("rst_valid",   32'(u_if.valid),      32'(0));
        check("rst_index",   32'(u_if.index),      32'(0));
        check("rst_x",       32'(u_if.x),          32'(0));
        check("rst_present", 32'(u_if.present),    32'(0));
        check("rst_done",    32'(u_if.frame_done), 32'(0));
        check("rst_count",   32'(frame_count),     32'(0));
        check("rst_overrun", 32'(overrun),         32'(0));
        rst_n = 1'b1;
        u_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", 32'(u_if.valid), 32'(0));

        // Frame 1: targets 0 and 2 detected.
        set_target(0, 100, 50, 12);
        set_target(2, 640, 360, 30);
        send_vsync(4'b0101);
        stream_all();

        // Target 1 detected once, then absent: coasts three frames, lost on the fourth.
        set_target(1, 200, 300, 20);
        send_vsync(4'b0010);
        stream_all();
        for (int f = 0; f < 4; f++) begin
            send_vsync(4'b0000);
            stream_all();
        end

        // vsync edge on the final handshake: back-to-back frames, no overrun.
        set_target(0, 11, 22, 5); set_target(1, 33, 44, 6);
        set_target(2, 55, 66, 7); set_target(3, 1279, 719, 8);
        send_vsync(4'b1111);
        for (int k = 0; k < NT - 1; k++) begin
            check_rec(k, e);
            @(negedge clk);
        end
        check_rec(NT - 1, e);
        set_target(0, 500, 400, 9); set_target(3, 7, 8, 3);
        drive_inputs(4'b1001);
        vsync = 1'b1;
        snapshot(4'b1001);
        @(negedge clk);
        vsync = 1'b0;
        check("coin_done",    32'(u_if.frame_done), 32'(1));
        check("coin_valid",   32'(u_if.valid),      32'(1));
        check("coin_overrun", 32'(overrun),         32'(0));
        check("coin_count",   32'(frame_count),     32'(exp_frames));
        stream_all();

        // Stall on index 1 for ten cycles with a vsync edge in the middle.
        set_target(1, 321, 123, 14); set_target(2, 999, 555, 40);
        send_vsync(4'b0110);
        check_rec(0, e);
        @(negedge clk);
        check_rec(1, stall_e);
        u_if.ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            if (s == 2) begin
                set_target(1, 1, 1, 1); set_target(2, 2, 2, 2);
                drive_inputs(4'b1111);
                vsync = 1'b1;
            end
            if (s == 3) vsync = 1'b0;
            check("stall_valid", 32'(u_if.valid), 32'(1));
            check("stall_index", 32'(u_if.index), 32'(1));
            check("stall_x",     32'(u_if.x),     32'(stall_e.x));
        end
        check("ovr_flag",  32'(overrun),     32'(1));
        check("ovr_count", 32'(frame_count), 32'(exp_frames));
        u_if.ready = 1'b1;
        @(negedge clk);
        check_rec(2, e);
        @(negedge clk);
        check_rec(3, e);
        @(negedge clk);
        check_done();
        check("ovr_sticky", 32'(overrun), 32'(1));
        send_vsync(4'b0000);
        stream_all();

        // Asynchronous reset in the middle of a frame.
        send_vsync(4'b1111);
        check_rec(0, e);
        @(negedge clk);
        check_rec(1, e);
        @(negedge clk);
        check("mid_index", 32'(u_if.index), 32'(2));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",   32'(u_if.valid),   32'(0));
        check("mid_rst_index",   32'(u_if.index),   32'(0));
        check("mid_rst_x",       32'(u_if.x),       32'(0));
        check("mid_rst_present", 32'(u_if.present), 32'(0));
        check("mid_rst_count",   32'(frame_count),  32'(0));
        check("mid_rst_overrun", 32'(overrun),      32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_target(0, 60, 70, 10); set_target(1, 80, 90, 11);
        send_vsync(4'b0011);
        stream_all();

        // Counter wrap: 2^FCW further frames bring the count back to 1.
        for (int f = 0; f < (1 << FCW); f++) begin
            @(negedge clk);
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
            repeat (5) @(negedge clk);
            exp_frames++;
        end
        check("wrap_count", 32'(frame_count), 32'(1));
        check("wrap_idle",  32'(u_if.valid),  32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
